mux_n_to_1_reg: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It is the next generation of the team's 2:1 4-bit combinational mux and adds:
- generic channel count and data width;
- a fixed-select mode and a round-robin mode;
- a one-entry output register with backpressure.

It sits between multiple producers and a single streaming consumer.

---
 rtl/mux_n_to_1_reg.sv | 130 +++++++++++++
 tb/tb_mux_n_to_1_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_reg.sv
// N-channel registered mux with valid/ready handshakes,
// fixed-select or round-robin arbitration, one-entry output stage.
module mux_n_to_1_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [CHANNELS*WIDTH-1:0] In,
  input  logic [CHANNELS-1:0]       In_valid,
  output logic [CHANNELS-1:0]       In_ready,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Sel,
  output logic [WIDTH-1:0]          Y,
  output logic                      Y_valid,
  input  logic                      Y_ready,
  output logic [SEL_W-1:0]          Y_sel
);

  localparam logic [SEL_W:0] NCH =
    (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0]      y_q, y_d;
  logic                  y_valid_q, y_valid_d;
  logic [SEL_W-1:0]      y_sel_q, y_sel_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;

  logic [2*CHANNELS-1:0] rot;
  logic [SEL_W-1:0]      rr_off;
  logic [SEL_W:0]        rr_sum;
  logic [SEL_W-1:0]      rr_cand;
  logic                  rr_ok;
  logic                  fix_ok;
  logic [SEL_W-1:0]      cand;
  logic                  grant_ok;
  logic                  load_en;
  logic                  xfer;
  logic [CHANNELS-1:0]   rdy;
  logic [WIDTH-1:0]      y_new;

  // Rotate valids so the search starts at ptr;
  // the doubled vector makes the wrap land on CHANNELS.
  always_comb begin
    rot    = {In_valid, In_valid} >> ptr_q;
    rr_ok  = 1'b0;
    rr_off = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        rr_ok  = 1'b1;
        rr_off = SEL_W'(j);
      end
    end
    rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
    if (rr_sum >= NCH) begin
      rr_sum = rr_sum - NCH;
    end
    rr_cand = rr_sum[SEL_W-1:0];
  end

  always_comb begin
    fix_ok = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (Sel == SEL_W'(k)) begin
        fix_ok = In_valid[k];
      end
    end
  end

  always_comb begin
    cand     = Mode ? rr_cand : Sel;
    grant_ok = Mode ? rr_ok : fix_ok;
    load_en  = !y_valid_q || Y_ready;
  end

  always_comb begin
    rdy   = '0;
    y_new = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cand == SEL_W'(k)) begin
        rdy[k] = grant_ok && load_en && Rst_n;
        y_new  = In[k*WIDTH +: WIDTH];
      end
    end
    xfer = |rdy;
  end

  always_comb begin
    y_d       = y_q;
    y_sel_d   = y_sel_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    unique case (1'b1)
      xfer: begin
        y_d       = y_new;
        y_sel_d   = cand;
        y_valid_d = 1'b1;
      end
      (!xfer && y_valid_q && Y_ready): begin
        y_valid_d = 1'b0;
      end
      default: ;
    endcase
    if (xfer && Mode) begin
      ptr_d = (cand == LAST) ? '0 : cand + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sel_q   <= '0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_sel_q   <= y_sel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign In_ready = rdy;
  assign Y        = y_q;
  assign Y_valid  = y_valid_q;
  assign Y_sel    = y_sel_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Bench for mux_n_to_1_reg: 4-channel and 3-channel
// instances, vector table plus output scoreboard.
module tb_mux_n_to_1_reg;

  typedef struct {
    bit       d3;
    bit       mode;
    bit [1:0] sel;
    bit [3:0] valid;
    bit       yr;
    bit [3:0] rdy;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic [1:0] s;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst3;
  logic [15:0] in4 = {4'hD, 4'hC, 4'hB, 4'hA};
  logic [11:0] in3 = {4'h7, 4'h6, 4'h5};
  logic [3:0]  valid4, rdy4, y4;
  logic [2:0]  valid3, rdy3;
  logic [3:0]  y3;
  logic        mode4, mode3, yr4, yr3;
  logic        yv4, yv3;
  logic [1:0]  sel4, sel3, ys4, ys3;

  int n_chk  = 0;
  int n_fail = 0;

  sb_t  q4[$];
  sb_t  q3[$];
  vec_t vecs[$];

  mux_n_to_1_reg #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .Clk(clk), .Rst_n(rst4), .In(in4),
    .In_valid(valid4), .In_ready(rdy4),
    .Mode(mode4), .Sel(sel4), .Y(y4),
    .Y_valid(yv4), .Y_ready(yr4), .Y_sel(ys4)
  );

  mux_n_to_1_reg #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .Clk(clk), .Rst_n(rst3), .In(in3),
    .In_valid(valid3), .In_ready(rdy3),
    .Mode(mode3), .Sel(sel3), .Y(y3),
    .Y_valid(yv3), .Y_ready(yr3), .Y_sel(ys3)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void add(bit d3, bit mode,
                              bit [1:0] sel, bit [3:0] valid,
                              bit yr, bit [3:0] rdy);
    vec_t v;
    v.d3 = d3; v.mode = mode; v.sel = sel;
    v.valid = valid; v.yr = yr; v.rdy = rdy;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v);
    sb_t e;
    if (v.d3) begin
      mode3 = v.mode; sel3 = v.sel;
      valid3 = v.valid[2:0]; yr3 = v.yr;
    end else begin
      mode4 = v.mode; sel4 = v.sel;
      valid4 = v.valid; yr4 = v.yr;
    end
    @(negedge clk);
    if (v.d3) begin
      chk("rdy3", 32'(rdy3), 32'(v.rdy[2:0]));
      chk("yv3", 32'(yv3), 32'(q3.size() > 0));
      if (q3.size() > 0) begin
        chk("y3", 32'(y3), 32'(q3[0].y));
        chk("ysel3", 32'(ys3), 32'(q3[0].s));
        if (v.yr) void'(q3.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        if (v.rdy[k]) begin
          e.y = 4'(in3 >> (4*k));
          e.s = 2'(k);
          q3.push_back(e);
        end
      end
    end else begin
      chk("rdy4", 32'(rdy4), 32'(v.rdy));
      chk("yv4", 32'(yv4), 32'(q4.size() > 0));
      if (q4.size() > 0) begin
        chk("y4", 32'(y4), 32'(q4[0].y));
        chk("ysel4", 32'(ys4), 32'(q4[0].s));
        if (v.yr) void'(q4.pop_front());
      end
      for (int k = 0; k < 4; k++) begin
        if (v.rdy[k]) begin
          e.y = 4'(in4 >> (4*k));
          e.s = 2'(k);
          q4.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 4-channel: fixed, round-robin, gap, backpressure
    add(0, 0, 2, 4'b1111, 1, 4'b0100);
    add(0, 0, 2, 4'b1111, 1, 4'b0100);
    add(0, 0, 2, 4'b1111, 1, 4'b0100);
    add(0, 1, 0, 4'b1111, 1, 4'b0001);
    add(0, 1, 0, 4'b1111, 1, 4'b0010);
    add(0, 1, 0, 4'b1111, 1, 4'b0100);
    add(0, 1, 0, 4'b1111, 1, 4'b1000);
    add(0, 1, 0, 4'b1111, 1, 4'b0001);
    add(0, 1, 0, 4'b1111, 1, 4'b0010);
    add(0, 1, 0, 4'b1111, 1, 4'b0100);
    add(0, 1, 0, 4'b1111, 1, 4'b1000);
    add(0, 1, 0, 4'b1010, 1, 4'b0010);
    add(0, 1, 0, 4'b1010, 1, 4'b1000);
    add(0, 1, 0, 4'b1010, 1, 4'b0010);
    add(0, 1, 0, 4'b1010, 1, 4'b1000);
    add(0, 0, 1, 4'b1111, 0, 4'b0000);
    add(0, 0, 1, 4'b1111, 0, 4'b0000);
    add(0, 0, 1, 4'b1111, 0, 4'b0000);
    add(0, 0, 1, 4'b1111, 1, 4'b0010);
    add(0, 0, 3, 4'b0111, 1, 4'b0000);
    add(0, 0, 3, 4'b0111, 1, 4'b0000);
    add(0, 1, 0, 4'b1111, 1, 4'b0001);
    add(0, 1, 0, 4'b0000, 0, 4'b0000);
    add(0, 1, 0, 4'b0000, 1, 4'b0000);
    add(0, 1, 0, 4'b0000, 1, 4'b0000);
    // 3-channel: out-of-range Sel, wrap at 3
    add(1, 0, 3, 4'b0111, 1, 4'b0000);
    add(1, 0, 0, 4'b0111, 1, 4'b0001);
    add(1, 0, 3, 4'b0111, 1, 4'b0000);
    add(1, 0, 3, 4'b0111, 1, 4'b0000);
    add(1, 1, 0, 4'b0010, 1, 4'b0010);
    add(1, 1, 0, 4'b0111, 1, 4'b0100);
    add(1, 1, 0, 4'b0111, 1, 4'b0001);

    rst4 = 1'b0; rst3 = 1'b0;
    mode4 = 1'b1; sel4 = 2'd0; valid4 = 4'b1111; yr4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b111; yr3 = 1'b1;
    #12;
    chk("rst_y4", 32'(y4), 32'h0);
    chk("rst_yv4", 32'(yv4), 32'h0);
    chk("rst_ysel4", 32'(ys4), 32'h0);
    chk("rst_rdy4", 32'(rdy4), 32'h0);
    chk("rst_rdy3", 32'(rdy3), 32'h0);
    valid3 = 3'b000;
    @(posedge clk);
    #1;
    rst4 = 1'b1; rst3 = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // async reset mid-stream on the 3-channel unit
    valid3 = 3'b111; mode3 = 1'b1;
    chk("pre_rst_yv3", 32'(yv3), 32'h1);
    rst3 = 1'b0;
    #1;
    chk("arst_yv3", 32'(yv3), 32'h0);
    chk("arst_y3", 32'(y3), 32'h0);
    chk("arst_ysel3", 32'(ys3), 32'h0);
    chk("arst_rdy3", 32'(rdy3), 32'h0);
    q3.delete();
    #1;
    rst3 = 1'b1;
    vecs.delete();
    add(1, 1, 0, 4'b0111, 1, 4'b0001);
    add(1, 1, 0, 4'b0111, 1, 4'b0010);
    add(1, 1, 0, 4'b0111, 1, 4'b0100);
    add(1, 1, 0, 4'b0000, 1, 4'b0000);
    foreach (vecs[i]) run_vec(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
